// File: rtl/slime_axi_pkg.sv
// Shared types and widths for the AXI-lite read path and its block-RAM responder.
package slime_axi_pkg;

    localparam int AXI_ADDR_BITS = 17;
    localparam int AXI_DATA_BITS = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } rd_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; head word shown as zero while empty.
// Latency: a push is visible at the head the cycle after it is written (no bypass).
// Backpressure: push ignored when full, pop ignored when empty; the caller owns flow control.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == (AW+1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/axi_read_master.sv
// Read initiator: one (addr, len) command becomes single-beat AR/R reads, data streamed out in order.
// Latency: cmd handshake -> arvalid next cycle; R beat -> out_valid next cycle (registered FIFO).
// Backpressure: out_ready low fills the FIFO and throttles AR issue via credits; R is always accepted.
module axi_read_master
    import slime_axi_pkg::*;
#(
    parameter int ADDR_BITS  = AXI_ADDR_BITS,
    parameter int DATA_BITS  = AXI_DATA_BITS,
    parameter int LEN_BITS   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [LEN_BITS-1:0]  cmd_len,
    output logic                 axi_arvalid,
    input  logic                 axi_arready,
    output logic [ADDR_BITS-1:0] axi_araddr,
    input  logic                 axi_rvalid,
    output logic                 axi_rready,
    input  logic [DATA_BITS-1:0] axi_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 1;

    rd_state_e            state, state_n;
    logic                 ready_q, done_q, busy_q, err_q, arvalid_q, arvalid_n;
    logic [ADDR_BITS-1:0] addr_q;
    logic [LEN_BITS-1:0]  len_q, len_n, issued_q, issued_n, popped_q;
    logic [CW-1:0]        outstanding_q, fifo_count;
    logic [SW-1:0]        credit_n;
    logic                 fifo_full, fifo_empty;
    logic                 cmd_fire, ar_fire, r_fire, stray_beat, pop, last_pop;

    assign cmd_ready  = ready_q && (state == IDLE) && !done_q;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign ar_fire    = arvalid_q && axi_arready;
    assign r_fire     = axi_rvalid && ready_q && (outstanding_q != '0);
    assign stray_beat = axi_rvalid && ready_q && (outstanding_q == '0);
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign out_last   = out_valid && (popped_q == len_q - LEN_BITS'(1));
    assign last_pop   = pop && out_last;

    assign axi_arvalid = arvalid_q;
    assign axi_araddr  = addr_q;
    assign axi_rready  = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_rdata_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (r_fire && !fifo_full),
        .push_data (axi_rdata),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n  = state;
        len_n    = len_q;
        issued_n = (state == IDLE) ? '0 : issued_q + LEN_BITS'(ar_fire);
        // Slots already promised (in flight or buffered) as they will stand next cycle.
        credit_n = SW'(outstanding_q) + SW'(fifo_count) + SW'(ar_fire) - SW'(pop);
        case (state)
            IDLE: begin
                if (cmd_fire && (cmd_len != '0)) begin
                    state_n = ISSUE;
                    len_n   = cmd_len;
                end
            end
            ISSUE:   if (issued_n == len_q) state_n = DRAIN;
            DRAIN:   if (last_pop) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (arvalid_q && !axi_arready) arvalid_n = 1'b1;
        else arvalid_n = (state_n == ISSUE) && (issued_n != len_n) && (credit_n < SW'(FIFO_DEPTH));
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            ready_q       <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            arvalid_q     <= 1'b0;
            addr_q        <= '0;
            len_q         <= '0;
            issued_q      <= '0;
            popped_q      <= '0;
            outstanding_q <= '0;
        end else begin
            ready_q       <= 1'b1;
            done_q        <= (cmd_fire && (cmd_len == '0)) || last_pop;
            err_q         <= err_q || stray_beat;
            arvalid_q     <= arvalid_n;
            len_q         <= len_n;
            issued_q      <= issued_n;
            popped_q      <= (state == IDLE) ? '0 : popped_q + LEN_BITS'(pop);
            outstanding_q <= outstanding_q + CW'(ar_fire) - CW'(r_fire);
            if (cmd_fire && (cmd_len != '0)) busy_q <= 1'b1;
            else if (done_q)                 busy_q <= 1'b0;
            if (cmd_fire)     addr_q <= cmd_addr;
            else if (ar_fire) addr_q <= addr_q + 1'b1;
        end
    end

endmodule

// File: doc/axi_read_master.md
# axi_read_master

Read-side AXI-lite initiator that turns a single (start address, word count) command into a sequence of single-beat AR/R transactions against the block-RAM responder, and delivers the returned words in order on a valid/ready output stream. It sits between compute/DMA logic and the AXI read port of the on-chip RAM. It is read-only; write channels are not ported.

## Interface
Parameters:
- ADDR_BITS, 17, word address width; matches the RAM responder.
- DATA_BITS, 64, data word width.
- LEN_BITS, 16, width of the command word count.
- FIFO_DEPTH, 4, return-data buffer depth; power of two, at least 2; also the maximum number of outstanding reads.

Ports:
- clock  in  1  clock, all logic on posedge.
- resetn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both high.
- cmd_addr  in  ADDR_BITS  first word address.
- cmd_len  in  LEN_BITS  number of words to read; 0 is legal.
- axi_arvalid  out  1  read address valid.
- axi_arready  in  1  read address accepted.
- axi_araddr  out  ADDR_BITS  read word address.
- axi_rvalid  in  1  read data valid.
- axi_rready  out  1  read data accept.
- axi_rdata  in  DATA_BITS  read data.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_BITS  output word.
- out_last  out  1  marks the final word of the command.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  sticky: R beat received with zero reads outstanding.

## Operation
- FSM states and transitions:
  - IDLE: cmd_ready=1. On handshake with cmd_len>0, latch addr/len and go to ISSUE. On handshake with cmd_len=0, pulse done the next cycle and stay in IDLE; no AXI traffic.
  - ISSUE: present axi_araddr = current address. Once the issue count reaches cmd_len, go to DRAIN.
  - DRAIN: wait until the last word is popped (out_valid && out_ready && out_last), pulse done, then go to IDLE.
- AR transfer rule: a transfer occurs when axi_arvalid && axi_arready. After a transfer, the address increments by 1 modulo 2^ADDR_BITS (wrap from all-ones to 0 is legal). Once raised, arvalid and araddr are held stable until arready.
- Credit rule: arvalid may rise only when outstanding + fifo_count < FIFO_DEPTH. This guarantees every returned beat has a slot, so axi_rready is held at 1 out of reset.
- R beats are pushed into the FIFO in arrival order; the responder returns data in order.
- out_last is high on the word whose pop completes cmd_len pops.
- Counters are LEN_BITS wide for issued and popped words, plus a clog2(FIFO_DEPTH)+1 wide outstanding counter.
- Simultaneous AR transfer and R beat in the same cycle: the outstanding count stays the same.
- An R beat with outstanding==0 is dropped and sets err. err clears only on reset.
- Reset mid-operation: all state is cleared. resetn is shared with the RAM responder, so no stale beats are expected.
- Reset values of outputs: cmd_ready 0, axi_arvalid 0, axi_araddr 0, axi_rready 0, out_valid 0, out_data 0, out_last 0, busy 0, done 0, err 0. cmd_ready and rready go to 1 in the first cycle after reset release.

## Timing
- A command handshake in cycle N gives arvalid=1 with araddr=cmd_addr in cycle N+1. busy is high from N+1 through the cycle done pulses; done and busy fall together the next cycle.
- Back-to-back AR: if arready is seen in cycle M and credit remains, arvalid stays high in M+1 with address+1.
- R-to-output latency: an rvalid in cycle K gives out_valid in cycle K+1 if the FIFO was empty (registered FIFO, no bypass).
- Throughput: one word per cycle when the responder and the downstream allow it. A full FIFO with out_ready=0 stalls AR issue only, never R acceptance.
- A new command is accepted no earlier than the cycle after done.

## Structure
- Package slime_axi_pkg holds:
  - the FSM state enum (IDLE/ISSUE/DRAIN);
  - default ADDR_BITS/DATA_BITS constants shared with the RAM responder.
- Sub-module sync_fifo, parameterised by width and depth. It provides push/pop, full/empty and a count output, and is instantiated once for return data.
- The top level holds the FSM, counters, credit logic and AR register.

## Test plan
- Memory preloaded with mem[i]=i*3; cmd addr=0x10, len=4 -> ARs at 0x10..0x13, out_data 0x30,0x33,0x36,0x39 in order, out_last on the 4th word only, one done pulse.
- cmd len=0 -> done one cycle after the handshake, no arvalid ever, busy stays 0.
- cmd addr=0x1FFFE, len=4 -> araddr sequence 0x1FFFE,0x1FFFF,0x00000,0x00001.
- Hold out_ready=0 with len=10, FIFO_DEPTH=4 -> exactly 4 ARs issued, then arvalid stays low. Release out_ready -> the remaining 6 words arrive, with no dropped or duplicated words.
- Inject rvalid while idle -> err=1 and remains set. A following len=2 command completes normally with err still 1.
- Assert resetn=0 mid-command (after 2 of 8 words) -> all outputs take their reset values. After release, a new len=3 command returns correct data.
